// File: rtl/irq_sequencer_pkg.sv
// rtl/irq_sequencer_pkg.sv - shared definitions for the SimpleRISC interrupt sequencer
//
// Purpose: FSM state encoding, default vector placement and the irq_id width
//          helper shared by the sequencer, its interface and its encoder.
// Ports:   none (package).

package simplerisc_irq_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_REDIRECT = 2'd1;
   localparam logic [1:0] ST_SERVICE  = 2'd2;
   localparam logic [1:0] ST_RETURN   = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      REDIRECT = ST_REDIRECT,
      SERVICE  = ST_SERVICE,
      RETURN   = ST_RETURN
   } irq_state_t;

   localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'd16;

   // clog2(n) with a floor of 1 so a single-line build still has an id bit.
   function automatic int IRQ_ID_W(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 6; i++) begin
         if ((1 << w) < n) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// rtl/irq_sequencer_if.sv - pipeline-facing signal bundle of the interrupt sequencer
//
// Purpose: groups the request, mask, PC-redirect and status signals.
// Ports:   none; modport slave is the sequencer, modport master is the
//          pipeline side (request sources, mask writer, PC/stall logic).

interface irq_sequencer_if
   import simplerisc_irq_pkg::*;
#(
   parameter int NUM_IRQ = 4
) ();

   localparam int ID_W = IRQ_ID_W(NUM_IRQ);

   logic [NUM_IRQ-1:0] irq_req;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic               add_stall;
   logic [31:0]        pcnext;
   logic               reti;

   logic               interrupt;
   logic [31:0]        pc_isr;
   logic [NUM_IRQ-1:0] irq_ack;
   logic [ID_W-1:0]    irq_id;
   logic [31:0]        epc;
   logic               in_isr;

   modport slave (
      input  irq_req, mask_we, mask_wdata, add_stall, pcnext, reti,
      output interrupt, pc_isr, irq_ack, irq_id, epc, in_isr
   );

   modport master (
      output irq_req, mask_we, mask_wdata, add_stall, pcnext, reti,
      input  interrupt, pc_isr, irq_ack, irq_id, epc, in_isr
   );

endinterface

// File: rtl/irq_sequencer_priority_enc.sv
// rtl/irq_sequencer_priority_enc.sv - lowest-index-wins priority encoder
//
// Purpose: picks the lowest set bit of pending.
// Ports:   pending (in)  request vector after masking
//          valid   (out) any bit of pending set
//          id      (out) index of the lowest set bit, 0 when none

module irq_priority_enc
   import simplerisc_irq_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = IRQ_ID_W(N)
) (
   input  logic [N-1:0]    pending,
   output logic            valid,
   output logic [ID_W-1:0] id
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) begin
            valid = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt sequencer for the SimpleRISC fetch stage
//
// Purpose: masks level requests, latches the winner, redirects the PC to its
//          vector, saves the return address and redirects back on reti.
// Ports:   clk   (in) clock, posedge
//          rst_n (in) asynchronous active-low reset
//          bus   (irq_sequencer_if.slave) requests, mask write, add_stall,
//                pcnext, reti in; interrupt, pc_isr, irq_ack, irq_id, epc,
//                in_isr out

module irq_sequencer
   import simplerisc_irq_pkg::*;
#(
   parameter int          NUM_IRQ    = 4,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   irq_sequencer_if.slave  bus
);

   localparam int ID_W = IRQ_ID_W(NUM_IRQ);

   irq_state_t         state_q;
   irq_state_t         state_d;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] pending;
   logic               win_valid;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    irq_id_q;
   logic [31:0]        epc_q;
   logic               accept;
   logic [31:0]        vec_addr;

   assign pending = bus.irq_req & mask_q;

   irq_priority_enc #(
      .N    (NUM_IRQ),
      .ID_W (ID_W)
   ) u_enc (
      .pending (pending),
      .valid   (win_valid),
      .id      (win_id)
   );

   // The PC takes the redirect on any REDIRECT edge that is not stalled.
   assign accept   = (state_q == REDIRECT) && !bus.add_stall;
   assign vec_addr = VEC_BASE + 32'(irq_id_q) * VEC_STRIDE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
      end else if (bus.mask_we) begin
         mask_q <= bus.mask_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The winner is only sampled from IDLE, so later mask writes or dropped
   // requests cannot retarget a redirect already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_id_q <= '0;
      end else if (state_q == IDLE && win_valid) begin
         irq_id_q <= win_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_q <= '0;
      end else if (accept) begin
         epc_q <= bus.pcnext;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (win_valid)                   state_d = REDIRECT;
         REDIRECT: if (!bus.add_stall)              state_d = SERVICE;
         // No nesting: pending requests are not looked at until back in IDLE.
         SERVICE:  if (bus.reti && !bus.add_stall)  state_d = RETURN;
         RETURN:   if (!bus.add_stall)              state_d = IDLE;
         default:                                   state_d = IDLE;
      endcase
   end

   // interrupt/pc_isr come only from registered state, irq_id and epc.
   always_comb begin
      bus.interrupt = 1'b0;
      bus.pc_isr    = '0;
      bus.in_isr    = 1'b0;
      case (state_q)
         REDIRECT: begin
            bus.interrupt = 1'b1;
            bus.pc_isr    = vec_addr;
         end
         SERVICE: begin
            bus.in_isr    = 1'b1;
         end
         RETURN: begin
            bus.interrupt = 1'b1;
            bus.pc_isr    = epc_q;
            bus.in_isr    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.irq_ack = '0;
      if (accept) bus.irq_ack[irq_id_q] = 1'b1;
   end

   assign bus.irq_id = irq_id_q;
   assign bus.epc    = epc_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed table-driven bench for irq_sequencer

module tb_irq_sequencer;

   typedef struct {
      logic [3:0]  req;
      logic        we;
      logic [3:0]  wdata;
      logic        stall;
      logic [31:0] pcn;
      logic        reti;
      logic        e_int;
      logic [31:0] e_pc_isr;
      logic [3:0]  e_ack;
      logic [1:0]  e_id;
      logic [31:0] e_epc;
      logic        e_isr;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   vec_t vq[$];

   irq_sequencer_if #(.NUM_IRQ(4)) bus ();

   irq_sequencer #(
      .NUM_IRQ    (4),
      .VEC_BASE   (32'h0000_0100),
      .VEC_STRIDE (32'd16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] req, input logic we, input logic [3:0] wd,
                      input logic st, input logic [31:0] pcn, input logic rt,
                      input logic ei, input logic [31:0] ep, input logic [3:0] ea,
                      input logic [1:0] eid, input logic [31:0] ee, input logic es);
      vec_t v;
      v.req = req; v.we = we; v.wdata = wd; v.stall = st; v.pcn = pcn; v.reti = rt;
      v.e_int = ei; v.e_pc_isr = ep; v.e_ack = ea; v.e_id = eid; v.e_epc = ee; v.e_isr = es;
      vq.push_back(v);
   endtask

   task automatic drive(input logic [3:0] req, input logic we, input logic [3:0] wd,
                        input logic st, input logic [31:0] pcn, input logic rt);
      bus.irq_req = req; bus.mask_we = we; bus.mask_wdata = wd;
      bus.add_stall = st; bus.pcnext = pcn; bus.reti = rt;
   endtask

   task automatic check_all(input string tag, input logic ei, input logic [31:0] ep,
                            input logic [3:0] ea, input logic [1:0] eid,
                            input logic [31:0] ee, input logic es);
      check({tag, ".interrupt"}, 32'(bus.interrupt), 32'(ei));
      check({tag, ".pc_isr"},    bus.pc_isr,         ep);
      check({tag, ".irq_ack"},   32'(bus.irq_ack),   32'(ea));
      check({tag, ".irq_id"},    32'(bus.irq_id),    32'(eid));
      check({tag, ".epc"},       bus.epc,            ee);
      check({tag, ".in_isr"},    32'(bus.in_isr),    32'(es));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drive(4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);

      // Masked requests: nothing happens for 10 cycles.
      for (int i = 0; i < 10; i++)
         add(4'hF, 0, 4'h0, 0, 32'h0, 0,   0, 32'h0,   4'h0, 0, 32'h0,  0);
      // Mask write 0110, then request 0110 -> winner 1, vector 0x110.
      add(4'h0, 1, 4'h6, 0, 32'h0,  0,     0, 32'h0,   4'h0, 0, 32'h0,  0);
      add(4'h6, 0, 4'h0, 0, 32'h40, 0,     0, 32'h0,   4'h0, 0, 32'h0,  0);
      add(4'h6, 0, 4'h0, 0, 32'h40, 0,     1, 32'h110, 4'h2, 1, 32'h0,  0);
      add(4'h0, 0, 4'h0, 0, 32'h44, 0,     0, 32'h0,   4'h0, 1, 32'h40, 1);
      // reti under stall is ignored, then accepted.
      add(4'h0, 0, 4'h0, 1, 32'h44, 1,     0, 32'h0,   4'h0, 1, 32'h40, 1);
      add(4'h0, 0, 4'h0, 0, 32'h44, 1,     0, 32'h0,   4'h0, 1, 32'h40, 1);
      // RETURN held by stall, then IDLE.
      add(4'h0, 0, 4'h0, 1, 32'h48, 0,     1, 32'h40,  4'h0, 1, 32'h40, 1);
      add(4'h0, 0, 4'h0, 0, 32'h48, 0,     1, 32'h40,  4'h0, 1, 32'h40, 1);
      add(4'h0, 0, 4'h0, 0, 32'h48, 0,     0, 32'h0,   4'h0, 1, 32'h40, 0);
      // IRQ 2, stalled three cycles with a request drop and a mask clear.
      add(4'h4, 0, 4'h0, 0, 32'h80, 0,     0, 32'h0,   4'h0, 1, 32'h40, 0);
      add(4'h4, 0, 4'h0, 1, 32'h84, 0,     1, 32'h120, 4'h0, 2, 32'h40, 0);
      add(4'h0, 1, 4'h0, 1, 32'h88, 0,     1, 32'h120, 4'h0, 2, 32'h40, 0);
      add(4'h0, 0, 4'h0, 1, 32'h8C, 0,     1, 32'h120, 4'h0, 2, 32'h40, 0);
      add(4'h0, 0, 4'h0, 0, 32'h90, 0,     1, 32'h120, 4'h4, 2, 32'h40, 0);
      add(4'h0, 1, 4'h7, 0, 32'h94, 0,     0, 32'h0,   4'h0, 2, 32'h90, 1);
      // reti together with irq_req[0]: return first, one IDLE, then vector 0x100.
      add(4'h1, 0, 4'h0, 0, 32'h94, 1,     0, 32'h0,   4'h0, 2, 32'h90, 1);
      add(4'h1, 0, 4'h0, 0, 32'h98, 0,     1, 32'h90,  4'h0, 2, 32'h90, 1);
      add(4'h1, 0, 4'h0, 0, 32'h98, 0,     0, 32'h0,   4'h0, 2, 32'h90, 0);
      add(4'h1, 0, 4'h0, 1, 32'h9C, 0,     1, 32'h100, 4'h0, 0, 32'h90, 0);
      add(4'h1, 0, 4'h0, 0, 32'hA0, 0,     1, 32'h100, 4'h1, 0, 32'h90, 0);
      add(4'h0, 0, 4'h0, 0, 32'hA4, 0,     0, 32'h0,   4'h0, 0, 32'hA0, 1);

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset", 0, 32'h0, 4'h0, 0, 32'h0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vq[k]) begin
         @(posedge clk);
         #1 drive(vq[k].req, vq[k].we, vq[k].wdata, vq[k].stall, vq[k].pcn, vq[k].reti);
         @(negedge clk);
         check_all($sformatf("vec%0d", k), vq[k].e_int, vq[k].e_pc_isr, vq[k].e_ack,
                   vq[k].e_id, vq[k].e_epc, vq[k].e_isr);
      end

      // Asynchronous reset mid-cycle while in SERVICE.
      #2 rst_n = 1'b0;
      #1 check_all("async_rst", 0, 32'h0, 4'h0, 0, 32'h0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(4'hF, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);

      // Mask must be back at 0: requests stay ignored.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_mask%0d.interrupt", i), 32'(bus.interrupt), 32'h0);
         check($sformatf("post_rst_mask%0d.in_isr", i), 32'(bus.in_isr), 32'h0);
      end

      // Re-enable line 0: one-cycle latency from pending to interrupt.
      @(posedge clk);
      #1 drive(4'hF, 1'b1, 4'h1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("relat_a.interrupt", 32'(bus.interrupt), 32'h0);
      @(posedge clk);
      #1 drive(4'hF, 1'b0, 4'h0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      check("relat_b.interrupt", 32'(bus.interrupt), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("relat_c.interrupt", 32'(bus.interrupt), 32'h1);
      check("relat_c.pc_isr", bus.pc_isr, 32'h100);
      check("relat_c.irq_ack", 32'(bus.irq_ack), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
